// File: rtl/general_cpu_pkg.sv
// Shared definitions for the general CPU: opcodes, controller state codes,
// accumulator source selects and the datapath control bundle.
package general_cpu_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned ASEL_W   = 2;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned ICOUNT_W = 8;

   localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'b000;
   localparam logic [OPCODE_W-1:0] OP_STORE = 3'b001;
   localparam logic [OPCODE_W-1:0] OP_ADD   = 3'b010;
   localparam logic [OPCODE_W-1:0] OP_SUB   = 3'b011;
   localparam logic [OPCODE_W-1:0] OP_IN    = 3'b100;
   localparam logic [OPCODE_W-1:0] OP_JZ    = 3'b101;
   localparam logic [OPCODE_W-1:0] OP_JPOS  = 3'b110;
   localparam logic [OPCODE_W-1:0] OP_HALT  = 3'b111;

   localparam logic [ASEL_W-1:0] ASEL_ALU = 2'b00;
   localparam logic [ASEL_W-1:0] ASEL_IN  = 2'b01;
   localparam logic [ASEL_W-1:0] ASEL_MEM = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      S_START  = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_LOAD   = 4'd3,
      S_STORE  = 4'd4,
      S_ADD    = 4'd5,
      S_SUB    = 4'd6,
      S_IN     = 4'd7,
      S_JZ     = 4'd8,
      S_JPOS   = 4'd9,
      S_HALT   = 4'd10
   } state_e;

   typedef struct packed {
      logic              pcload;
      logic              jmpmux;
      logic              irload;
      logic              meminst;
      logic              memwr;
      logic [ASEL_W-1:0] asel;
      logic              aload;
      logic              sub;
      logic              halt;
   } ctrl_t;

   // Execute state selected by an opcode.
   function automatic state_e decode_op(input logic [OPCODE_W-1:0] op);
      state_e s;
      case (op)
         OP_LOAD:  s = S_LOAD;
         OP_STORE: s = S_STORE;
         OP_ADD:   s = S_ADD;
         OP_SUB:   s = S_SUB;
         OP_IN:    s = S_IN;
         OP_JZ:    s = S_JZ;
         OP_JPOS:  s = S_JPOS;
         default:  s = S_HALT;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Registered rising-edge detector: remembers last cycle's level and flags
// the cycle in which the input goes from low to high.
module edge_detect_rise (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sig_q <= 1'b0;
      end else begin
         sig_q <= sig_i;
      end
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/general_controller.sv
// Control unit for the 8-bit general datapath: fetch/decode/execute sequencer
// driving all datapath controls, with Enter handshake, halt and instruction count.
module general_controller
   import general_cpu_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [OPCODE_W-1:0] ir_i,
   input  logic                aeq0_i,
   input  logic                apos_i,
   input  logic                enter_i,
   output logic                pcload_o,
   output logic                jmpmux_o,
   output logic                irload_o,
   output logic                meminst_o,
   output logic                memwr_o,
   output logic [ASEL_W-1:0]   asel_o,
   output logic                aload_o,
   output logic                sub_o,
   output logic                halt_o,
   output logic [STATE_W-1:0]  state_o,
   output logic [ICOUNT_W-1:0] instr_count_o
);

   state_e              state_q, state_d;
   ctrl_t               ctrl;
   logic                count_en;
   logic [ICOUNT_W-1:0] count_q;
   logic                enter_rise;

   edge_detect_rise u_enter_edge (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sig_i  (enter_i),
      .rise_o (enter_rise)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_START;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and control outputs; only PCload (jumps) and Aload (IN) look at inputs.
   always_comb begin
      state_d  = state_q;
      ctrl     = '0;
      count_en = 1'b0;
      case (state_q)
         S_START: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            ctrl.irload = 1'b1;
            ctrl.pcload = 1'b1;
            state_d     = S_DECODE;
         end
         S_DECODE: begin
            ctrl.meminst = 1'b1;
            state_d      = decode_op(ir_i);
         end
         S_LOAD: begin
            ctrl.meminst = 1'b1;
            ctrl.asel    = ASEL_MEM;
            ctrl.aload   = 1'b1;
            state_d      = S_FETCH;
            count_en     = 1'b1;
         end
         S_STORE: begin
            ctrl.meminst = 1'b1;
            ctrl.memwr   = 1'b1;
            state_d      = S_FETCH;
            count_en     = 1'b1;
         end
         S_ADD: begin
            ctrl.asel  = ASEL_ALU;
            ctrl.aload = 1'b1;
            state_d    = S_FETCH;
            count_en   = 1'b1;
         end
         S_SUB: begin
            ctrl.asel  = ASEL_ALU;
            ctrl.sub   = 1'b1;
            ctrl.aload = 1'b1;
            state_d    = S_FETCH;
            count_en   = 1'b1;
         end
         S_IN: begin
            // A level already high on entry is ignored; only a fresh press loads.
            ctrl.asel = ASEL_IN;
            if (enter_rise) begin
               ctrl.aload = 1'b1;
               state_d    = S_FETCH;
               count_en   = 1'b1;
            end
         end
         S_JZ: begin
            ctrl.jmpmux = 1'b1;
            ctrl.pcload = aeq0_i;
            state_d     = S_FETCH;
            count_en    = 1'b1;
         end
         S_JPOS: begin
            ctrl.jmpmux = 1'b1;
            ctrl.pcload = apos_i;
            state_d     = S_FETCH;
            count_en    = 1'b1;
         end
         S_HALT: begin
            ctrl.halt = 1'b1;
         end
         default: begin
            state_d = S_START;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else if (count_en) begin
         count_q <= count_q + ICOUNT_W'(1);
      end
   end

   assign pcload_o      = ctrl.pcload;
   assign jmpmux_o      = ctrl.jmpmux;
   assign irload_o      = ctrl.irload;
   assign meminst_o     = ctrl.meminst;
   assign memwr_o       = ctrl.memwr;
   assign asel_o        = ctrl.asel;
   assign aload_o       = ctrl.aload;
   assign sub_o         = ctrl.sub;
   assign halt_o        = ctrl.halt;
   assign state_o       = state_q;
   assign instr_count_o = count_q;

endmodule

// File: doc/general_controller.md
# general_controller

Control unit for the 8-bit general datapath: a Moore/Mealy FSM that sequences fetch, decode and execute for the 3-bit instruction set. It drives every datapath control line (PCload, JMPmux, IRload, Meminst, MemWr, Asel, Aload, Sub) from the opcode IR and the status flags Aeq0/Apos. It also handles the IN handshake with the user Enter key and signals halt. It sits beside GeneralDatapath in the top-level processor and shares its clock and reset.

## Interface
- No parameters; widths are fixed by the datapath: opcode 3 bits, Asel 2 bits, instruction counter 8 bits.
- Clock  in  1  system clock, rising-edge
- Reset  in  1  one clock; reset is asynchronous and active-high
- IR  in  3  opcode from datapath instruction register
- Aeq0  in  1  accumulator == 0
- Apos  in  1  accumulator > 0 (signed)
- Enter  in  1  user input-ready key, level, synchronous to Clock
- PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub  out  1 each  datapath controls
- Asel  out  2  accumulator source: 00 adder/subtractor, 01 data_in, 10 memory, 11 unused (never driven)
- Halt  out  1  processor halted
- State  out  4  current state code, for debug
- InstrCount  out  8  completed-instruction counter, wraps 255→0

## Operation
- States: START, FETCH, DECODE, LOAD, STORE, ADD, SUB, IN, JZ, JPOS, HALT.
- Opcodes: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 IN, 101 JZ, 110 JPOS, 111 HALT.
- Output defaults in every state: all control outputs 0 and Asel=00.
- START:
  - All controls 0.
  - Next state FETCH.
- FETCH:
  - IRload=1, PCload=1, JMPmux=0 (PC+1), Meminst=0 (address=PC).
  - Next state DECODE.
- DECODE:
  - Meminst=1, so the memory address is the IR operand field.
  - Next state is chosen from IR.
- LOAD: Meminst=1, Asel=10, Aload=1 → FETCH.
- STORE: Meminst=1, MemWr=1 → FETCH.
- ADD: Asel=00, Sub=0, Aload=1 → FETCH.
- SUB: Asel=00, Sub=1, Aload=1 → FETCH.
- IN:
  - Asel=01.
  - Aload=1 only in the cycle a rising edge of Enter is detected; that cycle also goes → FETCH.
  - Otherwise stay in IN.
- JZ: JMPmux=1, PCload=Aeq0 → FETCH.
- JPOS: JMPmux=1, PCload=Apos → FETCH.
- HALT:
  - Halt=1, all other controls 0.
  - Stay in HALT regardless of Enter; only Reset exits.
- Enter edge detect:
  - Register Enter_d each cycle; edge = Enter & ~Enter_d.
  - Enter held high on entry to IN does not load; a fresh press is required.
  - Enter_d resets to 0.
- InstrCount:
  - Increments on the clock edge leaving any execute state (LOAD..JPOS).
  - Does not count HALT.
  - Wraps modulo 256.

## Timing
- Reset:
  - Asynchronously forces state=START, Enter_d=0, InstrCount=0.
  - All control outputs, Halt and State drop within the same cycle, without waiting for a clock edge.
  - Reset asserted mid-instruction (for example during STORE) kills MemWr immediately; there is no partial completion.
- First FETCH occurs on the first rising edge after Reset deasserts.
- Instruction latency is 3 cycles: FETCH, DECODE, execute.
  - IN takes 3 cycles plus the number of cycles spent waiting for the Enter edge.
- IR is loaded at the end of FETCH and is valid throughout DECODE. It is sampled only in DECODE.
- Aeq0 and Apos are sampled combinationally during JZ/JPOS. They reflect A as of the previous instruction.
- Outputs are combinational from state, except two Mealy terms:
  - PCload in JZ/JPOS.
  - Aload in IN.
- State and InstrCount update on the same rising edge.

## Structure
- Shared package `general_cpu_pkg` holds:
  - Opcode localparams: OP_LOAD..OP_HALT.
  - State codes: S_START..S_HALT, 4 bits.
  - Asel codes: ASEL_ALU=00, ASEL_IN=01, ASEL_MEM=10.
- One sub-module: `edge_detect_rise`, a registered rising-edge detector with async active-high reset, used for Enter.
- Controller: one state register block, one next-state/output combinational block, one counter block.

## Test plan
- Reset=1 for 2 cycles, then release:
  - During reset, State=START, all outputs 0, InstrCount=0.
  - On the next edge, FETCH with IRload=PCload=1, JMPmux=0.
- IR=010 then IR=011:
  - ADD cycle shows Asel=00, Aload=1, Sub=0.
  - SUB cycle shows Sub=1.
  - InstrCount reads 2 after the second execute.
- IR=101 with Aeq0=1, then Aeq0=0:
  - JZ cycle shows JMPmux=1, PCload=1 in the first case.
  - PCload=0 with JMPmux=1 in the second case.
  - Repeat for IR=110 with Apos.
- IR=100 with Enter already high:
  - Stays in IN with Aload=0.
  - Drop Enter for 1 cycle, then raise it: Aload=1 for exactly 1 cycle, Asel=01, next state FETCH.
- IR=111:
  - Halt=1 from the HALT cycle onward; Enter toggling has no effect for 20 cycles; InstrCount does not change.
  - Reset returns to START with Halt=0.
- Reset mid-operation:
  - Assert Reset asynchronously mid-cycle in STORE: MemWr falls before the next edge and State=START.
  - Run 256 ADDs: InstrCount wraps to 0.
